instruction_fetch_arbiter: RTL and testbench

Shares a single instruction-memory read channel among the per-warp fetchers of a compute core. It accepts valid/ready fetch requests from `NUM_WARPS` fetchers, grants one at a time in round-robin order, and issues a single outstanding memory read. It returns the instruction to the granted fetcher as a one-cycle ready pulse with data. The block sits between the warp fetchers (downstream) and instruction memory (upstream).

---
 rtl/instruction_fetch_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_instruction_fetch_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_arbiter.sv
// instruction_fetch_arbiter
// Round-robin arbiter that shares one instruction-memory read channel among
// NUM_WARPS warp fetchers. Only one memory read is outstanding at a time, and
// each result goes back to its warp as a one-cycle ready pulse.
// Optional feature: define FETCH_ARB_LINE_BUFFER_EN to add a one-entry line
// buffer {valid, address, instruction}. A hit in the buffer skips memory, and
// flush invalidates the buffer.
module instruction_fetch_arbiter #(
  parameter int NUM_WARPS   = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WARPS-1:0]            fetch_req_valid,
  input  logic [NUM_WARPS*ADDR_WIDTH-1:0] fetch_req_address,
  output logic [NUM_WARPS-1:0]            fetch_req_ready,
  output logic [INSTR_WIDTH-1:0]          fetch_req_data,
  output logic                            mem_read_valid,
  output logic [ADDR_WIDTH-1:0]           mem_read_address,
  input  logic                            mem_read_ready,
  input  logic [INSTR_WIDTH-1:0]          mem_read_data,
  input  logic                            flush,
  output logic                            busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    RESPOND
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              rr_ptr_q, rr_ptr_d;
  logic [3:0]              grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [NUM_WARPS-1:0]    ready_q, ready_d;
  logic [INSTR_WIDTH-1:0]  data_q, data_d;
  logic                    busy_q, busy_d;

  logic                    lb_valid_q, lb_valid_d;
  logic [ADDR_WIDTH-1:0]   lb_addr_q, lb_addr_d;
  logic [INSTR_WIDTH-1:0]  lb_data_q, lb_data_d;

  // Per-warp addresses are padded out to 16 entries so that a 4-bit warp index
  // can select any of them directly.
  logic [ADDR_WIDTH-1:0]   addr_arr [16];
  logic [15:0]             valid_pad;
  logic                    win_found;
  logic [3:0]              win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    lb_hit;

  for (genvar g = 0; g < 16; g++) begin : g_addr_arr
    if (g < NUM_WARPS) begin : g_used
      assign addr_arr[g] = fetch_req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin : g_pad
      assign addr_arr[g] = '0;
    end
  end

  assign valid_pad = 16'(fetch_req_valid);
  assign win_addr  = addr_arr[win_idx];

  function automatic logic [NUM_WARPS-1:0] warp_onehot(input logic [3:0] idx);
    logic [15:0] w;
    w = 16'(1) << idx;
    return w[NUM_WARPS-1:0];
  endfunction

  // Round-robin search: start at rr_ptr, wrap modulo NUM_WARPS, and pick the
  // first warp whose valid bit is set.
  always_comb begin
    logic [4:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      cand = {1'b0, rr_ptr_q} + 5'(i);
      if (cand >= 5'(NUM_WARPS)) begin
        cand = cand - 5'(NUM_WARPS);
      end
      if (!win_found && valid_pad[cand[3:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

`ifdef FETCH_ARB_LINE_BUFFER_EN
  // A flush in the same cycle as the grant beats a stale hit.
  assign lb_hit = lb_valid_q && !flush && (lb_addr_q == win_addr);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign lb_hit       = 1'b0;
`endif

  // Next-state and registered-output logic for the fetch FSM and line buffer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    mem_valid_d = mem_valid_q;
    ready_d     = '0;
    data_d      = data_q;
    lb_valid_d  = lb_valid_q;
    lb_addr_d   = lb_addr_q;
    lb_data_d   = lb_data_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d  = win_idx;
          rr_ptr_d = (win_idx == 4'(NUM_WARPS - 1)) ? '0 : win_idx + 4'd1;
          addr_d   = win_addr;
          if (lb_hit) begin
            ready_d = warp_onehot(win_idx);
            data_d  = lb_data_q;
            state_d = RESPOND;
          end else begin
            mem_valid_d = 1'b1;
            state_d     = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (mem_read_ready) begin
          mem_valid_d = 1'b0;
          data_d      = mem_read_data;
          ready_d     = warp_onehot(grant_q);
          state_d     = RESPOND;
`ifdef FETCH_ARB_LINE_BUFFER_EN
          lb_valid_d  = 1'b1;
          lb_addr_d   = addr_q;
          lb_data_d   = mem_read_data;
`endif
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FETCH_ARB_LINE_BUFFER_EN
    // Flush drops any same-cycle buffer write, but the response is still
    // delivered to the warp.
    if (flush) begin
      lb_valid_d = 1'b0;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers; asynchronous reset abandons any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      mem_valid_q <= 1'b0;
      ready_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      lb_valid_q  <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      mem_valid_q <= mem_valid_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      lb_valid_q  <= lb_valid_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
    end
  end

  assign fetch_req_ready  = ready_q;
  assign fetch_req_data   = data_q;
  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = addr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// Testbench for instruction_fetch_arbiter: directed scenarios plus randomized
// fetcher/memory traffic, checked every cycle against a transaction-level model.
module tb_instruction_fetch_arbiter;

  localparam int NW = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NW-1:0]     fv;
  logic [AW-1:0]     req_addr [NW];
  logic [NW*AW-1:0]  fa;
  logic [NW-1:0]     fetch_req_ready;
  logic [DW-1:0]     fetch_req_data;
  logic              mem_read_valid;
  logic [AW-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DW-1:0]     mem_read_data;
  logic              flush;
  logic              busy;

  for (genvar g = 0; g < NW; g++) begin : g_fa
    assign fa[g*AW +: AW] = req_addr[g];
  end

  always #5 clk = ~clk;

  instruction_fetch_arbiter #(
    .NUM_WARPS  (NW),
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_req_valid  (fv),
    .fetch_req_address(fa),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_req_data   (fetch_req_data),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .flush            (flush),
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_own;     // warp currently being served, -1 when free
  bit            m_outst;   // memory read outstanding
  bit            m_resp;    // delivery cycle in progress
  int            m_rr;
  bit            lb_v;
  logic [AW-1:0] lb_a;
  logic [DW-1:0] lb_d;
  logic [NW-1:0] e_ready;
  logic [DW-1:0] e_data;
  logic          e_mvalid;
  logic [AW-1:0] e_addr;
  logic          e_busy;

  task automatic model_reset();
    m_own = -1; m_outst = 0; m_resp = 0; m_rr = 0; lb_v = 0; lb_a = '0; lb_d = '0;
    e_ready = '0; e_data = '0; e_mvalid = 0; e_addr = '0; e_busy = 0;
  endtask

  task automatic model_update();
    int g;
    bit hit;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_resp) begin
      m_resp = 0; m_own = -1; e_ready = '0;
    end else if (m_outst) begin
      if (mem_read_ready) begin
        m_outst = 0; m_resp = 1; e_mvalid = 0;
        e_data  = mem_read_data;
        e_ready = NW'(1) << m_own;
`ifdef FETCH_ARB_LINE_BUFFER_EN
        lb_v = 1; lb_a = e_addr; lb_d = mem_read_data;
`endif
      end
    end else if (fv != '0) begin
      g = -1;
      for (int k = 0; k < NW; k++) begin
        if (g < 0 && fv[(m_rr + k) % NW]) g = (m_rr + k) % NW;
      end
      m_rr   = (g + 1) % NW;
      m_own  = g;
      e_addr = req_addr[g];
      hit    = 0;
`ifdef FETCH_ARB_LINE_BUFFER_EN
      hit = lb_v && !flush && (lb_a == e_addr);
`endif
      if (hit) begin
        e_ready = NW'(1) << g; e_data = lb_d; m_resp = 1;
      end else begin
        m_outst = 1; e_mvalid = 1;
      end
    end
`ifdef FETCH_ARB_LINE_BUFFER_EN
    if (flush) lb_v = 0;
`endif
    e_busy = m_outst || m_resp;
  endtask

  task automatic check_all();
    chk("ready", fetch_req_ready, e_ready);
    chk("data", fetch_req_data, e_data);
    chk("mvalid", mem_read_valid, e_mvalid);
    chk("maddr", mem_read_address, e_addr);
    chk("busy", busy, e_busy);
  endtask

  // ---------------- environment: fetchers and memory ----------------
  bit          auto_req  = 0;
  bit          stray_en  = 0;
  bit          flush_en  = 0;
  bit          use_fixed = 0;
  logic [DW-1:0] fixed_data = '0;
  int          mem_delay = 0;
  int          cur_delay = 0;
  int          mcnt = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_env();
    bit rdy;
    for (int w = 0; w < NW; w++) begin
      if (fetch_req_ready[w]) fv[w] = 1'b0;
      else if (auto_req && !fv[w] && $urandom_range(0, 3) == 0) begin
        fv[w] = 1'b1;
        req_addr[w] = AW'(16'h20 + 16'($urandom_range(0, 3)) * 16'd4);
      end
    end
    if (auto_req && m_outst && m_own >= 0 && $urandom_range(0, 7) == 0)
      req_addr[m_own] = AW'($urandom);
    if (mem_read_valid) mcnt++; else mcnt = 0;
    if (mcnt == 1) cur_delay = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
    rdy = mem_read_valid && (mcnt == cur_delay + 1);
    if (!mem_read_valid && stray_en && $urandom_range(0, 5) == 0) rdy = 1'b1;
    mem_read_ready = rdy;
    if (rdy && mem_read_valid) mem_read_data = use_fixed ? fixed_data : mem_word(mem_read_address);
    else mem_read_data = DW'($urandom);
    flush = flush_en && ($urandom_range(0, 15) == 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_all();
    drive_env();
  endtask

  task automatic wait_ready(input int w, input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!fetch_req_ready[w] && k < 60);
    chk(tag, 64'(fetch_req_ready[w]), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fv = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int order[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    bit raise0, done0;
    reset = 1'b0; fv = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    for (int w = 0; w < NW; w++) req_addr[w] = '0;
    model_reset();

    // T1: reset values, then a single miss from warp 1.
    repeat (3) step();
    chk("rst_ready", fetch_req_ready, 0);
    chk("rst_data", fetch_req_data, 0);
    chk("rst_mvalid", mem_read_valid, 0);
    chk("rst_maddr", mem_read_address, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    fv[1] = 1'b1; req_addr[1] = 16'h10;
    use_fixed = 1; fixed_data = 32'hABCD1234; mem_delay = 1;
    step();
    chk("t1_maddr", mem_read_address, 16'h10);
    chk("t1_mvalid", mem_read_valid, 1);
    step();
    step();
    chk("t1_ready", fetch_req_ready, 4'b0010);
    chk("t1_data", fetch_req_data, 32'hABCD1234);
    step();
    chk("t1_busy_low", busy, 0);
    use_fixed = 0;

    // T2: all warps at once, then warp 0 re-requests behind pending warp 3.
    do_reset();
    mem_delay = 0;
    for (int w = 0; w < NW; w++) req_addr[w] = AW'(16'h100 + w * 4);
    fv = '1;
    raise0 = 0; done0 = 0;
    for (int k = 0; k < 80 && order.size() < 5; k++) begin
      step();
      if (raise0) begin fv[0] = 1'b1; raise0 = 0; end
      for (int w = 0; w < NW; w++) if (fetch_req_ready[w]) order.push_back(w);
      if (fetch_req_ready[0] && !done0) begin done0 = 1; raise0 = 1; end
    end
    chk("t2_count", 64'(order.size()), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("t2_order", 64'(order[i]), 64'(exp_ord[i]));
    repeat (3) step();

    // T3: memory withholds ready for 10 cycles.
    mem_delay = 10;
    fv[2] = 1'b1; req_addr[2] = 16'h3C;
    step();
    chk("t3_mvalid0", mem_read_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_mvalid", mem_read_valid, 1);
      chk("t3_maddr", mem_read_address, 16'h3C);
      chk("t3_noready", fetch_req_ready, 0);
    end
    step();
    chk("t3_ready", fetch_req_ready, 4'b0100);
    step();

    // T4: asynchronous reset during REQUEST, then a stray memory strobe.
    mem_delay = 20;
    fv[3] = 1'b1; req_addr[3] = 16'h44;
    step();
    step();
    chk("t4_in_request", mem_read_valid, 1);
    #2;
    reset = 1'b0; fv = '0;
    #1;
    chk("t4_async_mvalid", mem_read_valid, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_maddr", mem_read_address, 0);
    step();
    reset = 1'b1;
    mem_read_ready = 1'b1;
    step();
    chk("t4_stray_ready", fetch_req_ready, 0);
    chk("t4_stray_mvalid", mem_read_valid, 0);
    step();
    chk("t4_stray_ready2", fetch_req_ready, 0);

    // T5: repeated fetch of 0x20 (line buffer hit when enabled), then flush.
    mem_delay = 0;
    fv[0] = 1'b1; req_addr[0] = 16'h20;
    wait_ready(0, "t5_first_timeout");
    step();
    fv[2] = 1'b1; req_addr[2] = 16'h20;
    step();
`ifdef FETCH_ARB_LINE_BUFFER_EN
    chk("t5_hit_ready", fetch_req_ready, 4'b0100);
    chk("t5_hit_nomem", mem_read_valid, 0);
    chk("t5_hit_data", fetch_req_data, mem_word(16'h20));
`else
    chk("t5_miss_mvalid", mem_read_valid, 1);
    chk("t5_miss_noready", fetch_req_ready, 0);
`endif
    wait_ready(2, "t5_second_timeout");
    step();
    fv[0] = 1'b1; req_addr[0] = 16'h20;
    wait_ready(0, "t5_third_timeout");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    fv[2] = 1'b1; req_addr[2] = 16'h20;
    step();
    chk("t5_flush_mvalid", mem_read_valid, 1);
    wait_ready(2, "t5_flush_timeout");
    step();

    // T6: granted warp changes its address while the read is pending.
    mem_delay = 5;
    fv[1] = 1'b1; req_addr[1] = 16'h50;
    step();
    chk("t6_maddr0", mem_read_address, 16'h50);
    req_addr[1] = 16'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_maddr", mem_read_address, 16'h50);
    end
    wait_ready(1, "t6_timeout");
    step();

    // Randomized traffic.
    auto_req = 1; stray_en = 1; flush_en = 1; mem_delay = -1;
    repeat (3000) step();
    auto_req = 0; stray_en = 0; flush_en = 0;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
